// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART frame definitions used by transmit and receive.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } frame_state_t;

endpackage
`default_nettype wire

// File: rtl/transmit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fifo
// Brief    : Show-ahead byte buffer with wrap-around pointers and registered
//            full/empty flags.
// Revision : 1.0
// ============================================================================
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdat,
    input  logic             rd,
    output logic [WIDTH-1:0] rdat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      wptr_d;
    logic [AW:0]      rptr_q;
    logic [AW:0]      rptr_d;
    logic             full_q;
    logic             empty_q;
    logic             w_wr;
    logic             w_rd;

    assign w_wr   = wr & ~full_q;
    assign w_rd   = rd & ~empty_q;
    assign wptr_d = wptr_q + {{AW{1'b0}}, w_wr};
    assign rptr_d = rptr_q + {{AW{1'b0}}, w_rd};

    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem_q[wptr_q[AW-1:0]] <= wdat;
        end
    end

    // Flags are registered from the next pointers so they never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            full_q  <= (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
            empty_q <= (wptr_d == rptr_d);
        end
    end

    assign rdat  = mem_q[rptr_q[AW-1:0]];
    assign full  = full_q;
    assign empty = empty_q;

endmodule
`default_nettype wire

// File: rtl/transmit.sv
`default_nettype none
// ============================================================================
// Module   : transmit
// Brief    : Buffered 8N1 UART transmitter with registered line outputs.
// Revision : 1.0
// ============================================================================
module transmit
    import uart_pkg::*;
#(
    parameter real BAUDRATE  = 96e2,
    parameter real FREQUENCY = 12e6,
    parameter int  DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stb,
    input  logic [DATA_BITS-1:0] dat,
    output logic                 rdy,
    output logic                 txd,
    output logic                 bsy
);

    localparam int             CYCLES    = $rtoi(FREQUENCY / BAUDRATE);
    localparam int             CW        = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0]  BAUD_LAST = CW'(CYCLES - 1);
    localparam logic [2:0]     BIT_LAST  = 3'(DATA_BITS - 1);

    frame_state_t         state_q;
    frame_state_t         state_d;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] shreg_d;
    logic [2:0]           bitcnt_q;
    logic [2:0]           bitcnt_d;
    logic [CW-1:0]        baud_q;
    logic [CW-1:0]        baud_d;
    logic                 txd_q;
    logic                 txd_d;
    logic                 bsy_q;
    logic                 bsy_d;
    logic                 live_q;

    logic                 w_wr;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_baud_end;
    logic [DATA_BITS-1:0] w_rdat;

    fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (w_wr),
        .wdat  (dat),
        .rd    (w_pop),
        .rdat  (w_rdat),
        .full  (w_full),
        .empty (w_empty)
    );

    // live_q holds rdy low through reset and releases it on the first edge after.
    assign rdy        = live_q & ~w_full;
    assign w_wr       = stb & rdy;
    assign w_baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        baud_d   = baud_q;
        txd_d    = txd_q;
        w_pop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    shreg_d = w_rdat;
                    txd_d   = 1'b0;
                    baud_d  = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (w_baud_end) begin
                    baud_d   = '0;
                    txd_d    = shreg_q[0];
                    shreg_d  = {1'b0, shreg_q[DATA_BITS-1:1]};
                    bitcnt_d = '0;
                    state_d  = ST_DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (w_baud_end) begin
                    baud_d = '0;
                    if (bitcnt_q == BIT_LAST) begin
                        txd_d   = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        txd_d    = shreg_q[0];
                        shreg_d  = {1'b0, shreg_q[DATA_BITS-1:1]};
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (w_baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!w_empty) begin
                        w_pop   = 1'b1;
                        shreg_d = w_rdat;
                        txd_d   = 1'b0;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A write this edge makes the buffer non-empty; a pop only happens when leaving IDLE/STOP for START.
    assign bsy_d = (state_d != ST_IDLE) | ~w_empty | w_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            baud_q   <= '0;
            txd_q    <= 1'b1;
            bsy_q    <= 1'b0;
            live_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            baud_q   <= baud_d;
            txd_q    <= txd_d;
            bsy_q    <= bsy_d;
            live_q   <= 1'b1;
        end
    end

    assign txd = txd_q;
    assign bsy = bsy_q;

endmodule
`default_nettype wire
